// File: rtl/pe_array_pkg.sv
// Shared widths and state encoding for the pe_array front-end feeder.
package pe_array_pkg;

    localparam int unsigned IACT_W   = 32;
    localparam int unsigned WEIGHT_W = 16;
    localparam int unsigned PSUM_W   = 48;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN
    } feeder_state_e;

endpackage

// File: rtl/skew_line.sv
// Data+valid delay line of DEPTH register stages; every valid tap is exposed
// so callers can observe intermediate delays.
module skew_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [DEPTH:0]   o_valid_taps
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_data       = i_valid ? i_data : '0;
            assign o_valid_taps = i_valid;
        end else begin : g_delay
            logic [WIDTH-1:0] r_data [DEPTH];
            logic [DEPTH-1:0] r_valid;

            // Data is zeroed on entry when invalid, so bubbles stay zero downstream.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= '0;
                    for (int unsigned k = 0; k < DEPTH; k++) begin
                        r_data[k] <= '0;
                    end
                end else begin
                    r_valid[0] <= i_valid;
                    r_data[0]  <= i_valid ? i_data : '0;
                    for (int unsigned k = 1; k < DEPTH; k++) begin
                        r_valid[k] <= r_valid[k-1];
                        r_data[k]  <= r_data[k-1];
                    end
                end
            end

            assign o_data       = r_data[DEPTH-1];
            assign o_valid_taps = {r_valid, i_valid};
        end
    endgenerate

endmodule

// File: rtl/pe_array_feeder.sv
// Front-end sequencer for a weight-stationary pe_array: loads weight columns,
// streams skewed activations and flags when each psum row is valid.
module pe_array_feeder
    import pe_array_pkg::*;
#(
    parameter int unsigned ROWS = 3,
    parameter int unsigned COLS = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [0:ROWS-1][WEIGHT_W-1:0]    w_data,
    input  logic                             x_valid,
    output logic                             x_ready,
    input  logic [0:COLS-1][IACT_W-1:0]      x_data,
    input  logic                             x_last,
    output logic [0:COLS-1][IACT_W-1:0]      iacts,
    output logic [0:ROWS-1][WEIGHT_W-1:0]    weights,
    output logic                             load_weight,
    output logic [0:ROWS-1]                  psum_valid,
    output logic                             busy
);

    localparam int unsigned BEAT_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned PV_DEPTH = ROWS + COLS - 1;

    feeder_state_e r_state;
    feeder_state_e w_next_state;

    logic [BEAT_W-1:0]                 r_beat;
    logic                              r_load_weight;
    logic [0:ROWS-1][WEIGHT_W-1:0]     r_weights;
    logic [0:COLS-1][IACT_W-1:0]       r_x_data;
    logic                              r_x_valid;

    logic                              w_wt_accept;
    logic                              w_vec_accept;
    logic [PV_DEPTH:0]                 w_pv_taps;
    logic                              w_pipe_empty;
    logic                              w_unused_pv_data;

    assign w_wt_accept  = w_valid && w_ready;
    assign w_vec_accept = x_valid && x_ready;

    // The last tap is the final row's psum_valid; only earlier taps can still produce output.
    assign w_pipe_empty = ~|w_pv_taps[PV_DEPTH-1:0];

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        x_ready      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    w_next_state = (COLS == 1) ? STREAM : LOAD;
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_valid && (r_beat == BEAT_W'(COLS - 1))) begin
                    w_next_state = STREAM;
                end
            end
            STREAM: begin
                x_ready = 1'b1;
                if (x_valid && x_last) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pipe_empty) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_wt_accept) begin
                r_beat <= (r_state == IDLE) ? BEAT_W'(1) : r_beat + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_weight <= 1'b0;
            r_weights     <= '0;
            r_x_valid     <= 1'b0;
            r_x_data      <= '0;
        end else begin
            r_load_weight <= w_wt_accept;
            r_weights     <= w_wt_accept ? w_data : '0;
            r_x_valid     <= w_vec_accept;
            r_x_data      <= w_vec_accept ? x_data : '0;
        end
    end

    genvar j;
    generate
        for (j = 0; j < COLS; j++) begin : g_col
            logic [j:0] w_unused_taps;
            skew_line #(
                .DEPTH(j),
                .WIDTH(IACT_W)
            ) u_skew (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_data      (r_x_data[j]),
                .i_valid     (r_x_valid),
                .o_data      (iacts[j]),
                .o_valid_taps(w_unused_taps)
            );
        end
    endgenerate

    skew_line #(
        .DEPTH(PV_DEPTH),
        .WIDTH(1)
    ) u_psum_valid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_data      (1'b0),
        .i_valid     (r_x_valid),
        .o_data      (w_unused_pv_data),
        .o_valid_taps(w_pv_taps)
    );

    genvar i;
    generate
        for (i = 0; i < ROWS; i++) begin : g_row
            assign psum_valid[i] = w_pv_taps[COLS + i];
        end
    endgenerate

    assign load_weight = r_load_weight;
    assign weights     = r_weights;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_pe_array_feeder.sv
// Scoreboard bench for pe_array_feeder: expectations are queued at each
// handshake and compared when their due cycle arrives.
module tb_pe_array_feeder;

    localparam int unsigned ROWS = 3;
    localparam int unsigned COLS = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    w_valid;
    logic                    w_ready;
    logic [0:ROWS-1][15:0]   w_data;
    logic                    x_valid;
    logic                    x_ready;
    logic [0:COLS-1][31:0]   x_data;
    logic                    x_last;
    logic [0:COLS-1][31:0]   iacts;
    logic [0:ROWS-1][15:0]   weights;
    logic                    load_weight;
    logic [0:ROWS-1]         psum_valid;
    logic                    busy;

    pe_array_feeder #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .x_last     (x_last),
        .iacts      (iacts),
        .weights    (weights),
        .load_weight(load_weight),
        .psum_valid (psum_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned            due;
        logic [0:ROWS-1][15:0]  val;
    } exp_w_t;

    typedef struct {
        int unsigned  due;
        logic [31:0]  val;
    } exp_x_t;

    exp_w_t      w_q[$];
    exp_x_t      x_q[COLS][$];
    int unsigned pv_q[ROWS][$];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    exp_w_t mw;
    exp_x_t mx;
    logic   exp_pv;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_w_ready", 64'(w_ready), 64'd1);
            chk("rst_x_ready", 64'(x_ready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_load_weight", 64'(load_weight), 64'd0);
            chk("rst_weights", 64'(weights), 64'd0);
            chk("rst_psum_valid", 64'(psum_valid), 64'd0);
            for (int unsigned j = 0; j < COLS; j++) begin
                chk($sformatf("rst_iacts[%0d]", j), 64'(iacts[j]), 64'd0);
                x_q[j].delete();
            end
            for (int unsigned r = 0; r < ROWS; r++) pv_q[r].delete();
            w_q.delete();
        end else begin
            if (w_q.size() > 0 && w_q[0].due == cyc) begin
                mw = w_q.pop_front();
                chk("load_weight", 64'(load_weight), 64'd1);
                chk("weights", 64'(weights), 64'(mw.val));
            end else begin
                chk("load_weight_off", 64'(load_weight), 64'd0);
                chk("weights_off", 64'(weights), 64'd0);
            end
            for (int unsigned j = 0; j < COLS; j++) begin
                if (x_q[j].size() > 0 && x_q[j][0].due == cyc) begin
                    mx = x_q[j].pop_front();
                    chk($sformatf("iacts[%0d]", j), 64'(iacts[j]), 64'(mx.val));
                end else begin
                    chk($sformatf("iacts[%0d]_bubble", j), 64'(iacts[j]), 64'd0);
                end
            end
            for (int unsigned r = 0; r < ROWS; r++) begin
                exp_pv = (pv_q[r].size() > 0 && pv_q[r][0] == cyc);
                if (exp_pv) void'(pv_q[r].pop_front());
                chk($sformatf("psum_valid[%0d]", r), 64'(psum_valid[r]), 64'(exp_pv));
            end
            if (w_valid && w_ready) begin
                mw.due = cyc + 1;
                mw.val = w_data;
                w_q.push_back(mw);
            end
            if (x_valid && x_ready) begin
                for (int unsigned j = 0; j < COLS; j++) begin
                    mx.due = cyc + 1 + j;
                    mx.val = x_data[j];
                    x_q[j].push_back(mx);
                end
                for (int unsigned r = 0; r < ROWS; r++) pv_q[r].push_back(cyc + 1 + COLS + r);
            end
        end
    end

    function automatic logic [0:ROWS-1][15:0] rand_w();
        logic [0:ROWS-1][15:0] v;
        for (int unsigned r = 0; r < ROWS; r++) v[r] = 16'($urandom);
        return v;
    endfunction

    function automatic logic [0:COLS-1][31:0] rand_x();
        logic [0:COLS-1][31:0] v;
        for (int unsigned j = 0; j < COLS; j++) v[j] = $urandom;
        return v;
    endfunction

    task automatic send_w(input logic [0:ROWS-1][15:0] d);
        w_valid = 1'b1;
        w_data  = d;
        for (int unsigned t = 0; t < 50; t++) begin
            @(negedge clk);
            if (w_ready) begin
                @(posedge clk);
                #1;
                w_valid = 1'b0;
                return;
            end
        end
        chk("w_handshake_timeout", 64'(w_ready), 64'd1);
        w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [0:COLS-1][31:0] d, input logic last);
        x_valid = 1'b1;
        x_data  = d;
        x_last  = last;
        for (int unsigned t = 0; t < 50; t++) begin
            @(negedge clk);
            if (x_ready) begin
                @(posedge clk);
                #1;
                x_valid = 1'b0;
                x_last  = 1'b0;
                return;
            end
        end
        chk("x_handshake_timeout", 64'(x_ready), 64'd1);
        x_valid = 1'b0;
        x_last  = 1'b0;
    endtask

    task automatic load_rand();
        for (int unsigned k = 0; k < COLS; k++) send_w(rand_w());
    endtask

    task automatic wait_idle();
        int unsigned t = 0;
        while (busy && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_to_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t;
        int unsigned pending;

        // Reset with arbitrary inputs driven.
        rst_n   = 1'b0;
        w_valid = 1'b1;
        x_valid = 1'b1;
        x_last  = 1'b1;
        w_data  = rand_w();
        x_data  = rand_x();
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        w_valid = 1'b0;
        x_valid = 1'b0;
        x_last  = 1'b0;

        // Back-to-back weight load.
        w_valid = 1'b1;
        w_data  = {16'd1, 16'd2, 16'd3};
        @(posedge clk); #1;
        chk("x_ready_in_load", 64'(x_ready), 64'd0);
        chk("w_ready_in_load", 64'(w_ready), 64'd1);
        w_data = {16'd4, 16'd5, 16'd6};
        @(posedge clk); #1;
        w_data = {16'd7, 16'd8, 16'd9};
        @(posedge clk); #1;
        w_valid = 1'b0;
        chk("x_ready_after_load", 64'(x_ready), 64'd1);
        chk("w_ready_in_stream", 64'(w_ready), 64'd0);
        chk("busy_in_stream", 64'(busy), 64'd1);

        // Single last vector, then drain timing.
        x_data  = {32'd1, 32'd2, 32'd3};
        x_last  = 1'b1;
        x_valid = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
        x_last  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_in_drain", 64'(busy), 64'd1);
        chk("w_ready_in_drain", 64'(w_ready), 64'd0);
        @(posedge clk); #1;
        chk("busy_after_drain", 64'(busy), 64'd0);
        chk("w_ready_after_drain", 64'(w_ready), 64'd1);

        // Stream with a one-cycle bubble between vectors 2 and 3.
        load_rand();
        send_x(rand_x(), 1'b0);
        send_x(rand_x(), 1'b0);
        @(posedge clk); #1;
        send_x(rand_x(), 1'b0);
        send_x(rand_x(), 1'b1);
        wait_idle();

        // Gapped weight beats with a vector offered early.
        x_valid = 1'b1;
        x_data  = rand_x();
        x_last  = 1'b1;
        @(negedge clk);
        chk("x_ready_idle", 64'(x_ready), 64'd0);
        @(posedge clk); #1;
        for (int unsigned k = 0; k < 5; k++) begin
            w_valid = (k % 2 == 0);
            w_data  = rand_w();
            @(negedge clk);
            chk("x_ready_during_load", 64'(x_ready), 64'd0);
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        @(negedge clk);
        chk("x_ready_stream_gapped", 64'(x_ready), 64'd1);
        @(posedge clk); #1;
        x_valid = 1'b0;
        x_last  = 1'b0;
        wait_idle();

        // Reset while draining.
        load_rand();
        send_x(rand_x(), 1'b0);
        send_x(rand_x(), 1'b1);
        t = 0;
        while (!psum_valid[1] && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("psum_valid1_seen", 64'(psum_valid[1]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_drain_psum_valid", 64'(psum_valid), 64'd0);
        chk("rst_drain_busy", 64'(busy), 64'd0);
        for (int unsigned j = 0; j < COLS; j++) begin
            chk($sformatf("rst_drain_iacts[%0d]", j), 64'(iacts[j]), 64'd0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_w_ready", 64'(w_ready), 64'd1);
        chk("post_rst_x_ready", 64'(x_ready), 64'd0);

        // Full pass after reset, back-to-back vectors.
        load_rand();
        send_x(rand_x(), 1'b0);
        send_x(rand_x(), 1'b0);
        send_x(rand_x(), 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        pending = w_q.size();
        for (int unsigned j = 0; j < COLS; j++) pending += x_q[j].size();
        for (int unsigned r = 0; r < ROWS; r++) pending += pv_q[r].size();
        chk("scoreboard_drained", 64'(pending), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_array_feeder.md
# pe_array_feeder

Front-end sequencer that drives a weight-stationary `pe_array`. It accepts weight columns and activation vectors over valid/ready streams and shifts the weights into the array. It then streams activations with the per-column skew the array requires, and tells the psum consumer exactly when each row's `psums[i]` holds a valid result. It sits between the on-chip buffers and the array; its outputs connect port-for-port to the array inputs.

## Interface
- `ROWS`, 3: array rows, i.e. weights per column beat and psum rows tracked.
- `COLS`, 3: array columns, i.e. activation elements per vector and weight beats per load.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `w_valid`  in  1  weight beat offered.
- `w_ready`  out  1  weight beat accepted when both are high.
- `w_data`  in  `[0:ROWS-1][15:0]`  one weight column; element i goes to row i.
- `x_valid`  in  1  activation vector offered.
- `x_ready`  out  1  vector accepted when both are high.
- `x_data`  in  `[0:COLS-1][31:0]`  activation vector; element j goes to column j.
- `x_last`  in  1  final vector of the current pass.
- `iacts`  out  `[0:COLS-1][31:0]`  to the array.
- `weights`  out  `[0:ROWS-1][15:0]`  to the array.
- `load_weight`  out  1  to the array; asserted only to shift weights.
- `psum_valid`  out  `[0:ROWS-1]`  `psums[i]` of the array is valid this cycle.
- `busy`  out  1  state is not IDLE.

## Operation
- Array contract: every PE registers `iact_out`, `weight_out` and `psum_out` with one cycle of latency. A weight shifts one column per cycle while `load_weight` is high.
- States: IDLE, LOAD, STREAM, DRAIN.
- IDLE:
  - `w_ready`=1, `x_ready`=0.
  - An accepted weight beat counts as beat 0 and moves the state to LOAD.
- LOAD:
  - `w_ready`=1.
  - Beats are counted 0..COLS-1; after COLS accepted beats, go to STREAM.
  - Beat k lands in column COLS-1-k, so upstream sends the last column first.
  - Gaps in `w_valid` are allowed; the array shifts only on accepted beats.
- STREAM:
  - `x_ready`=1, `w_ready`=0.
  - Each accepted vector is registered and enters the skew line.
  - When `x_valid`=0, zeros are injected with valid=0 (a bubble).
  - Accepting a vector with `x_last`=1 moves the state to DRAIN on the same edge.
- DRAIN:
  - `x_ready`=0, `w_ready`=0.
  - Return to IDLE when the valid pipeline is empty.
- Reloading weights is only possible from IDLE. The loaded weights persist for later passes, but every pass starts with a full COLS-beat load.
- Skew: column j's element is delayed j cycles after column 0. Each column carries a valid bit; invalid slots drive `iacts[j]`=0.
- Valid tracking: a shift register of depth ROWS+COLS-1 is fed by the column-0 valid bit. `psum_valid[i]` is the tap for a delay of COLS+i cycles.
- `load_weight` and `weights` are registered. `weights` is 0 whenever `load_weight` is 0.
- Reset mid-operation: all state, skew registers and valid bits clear immediately. Array contents are stale, so upstream must reload weights.

## Timing
- Reset values:
  - `iacts`=0, `weights`=0, `load_weight`=0, `psum_valid`=0, `busy`=0.
  - `w_ready`=1, `x_ready`=0.
- Weight beat accepted at edge A: `load_weight`=1 and `weights`=`w_data` during cycle A+1.
- LOAD→STREAM: `x_ready`=1 from the cycle after the final beat's accept edge.
- Vector accepted at edge A: let T=A+1. `iacts[j]` carries `x_data[j]` during cycle T+j.
- `psum_valid[i]`=1 during cycle T+COLS+i; the result is sum over j of w[i][j]·x[j].
- Last vector accepted at edge L: `psum_valid[ROWS-1]` is high at L+1+COLS+ROWS-1. The state is IDLE, with `w_ready`=1 and `busy`=0, on the following cycle.
- COLS=1: no skew; `iacts[0]` is valid at T.
- Back-to-back vectors give back-to-back `psum_valid` per row, with no gaps and no overlap.

## Structure
- `pe_array_pkg` holds:
  - `IACT_W`=32, `WEIGHT_W`=16, `PSUM_W`=48.
  - The `feeder_state_e` enum (IDLE/LOAD/STREAM/DRAIN).
- Sub-module `skew_line`: parameterized DEPTH and WIDTH, a data+valid delay line.
  - Instantiate it once per column with DEPTH=j.
  - Instantiate it once more for the psum valid pipeline.

## Test plan
- Reset: hold `rst_n`=0, drive arbitrary inputs → all outputs at their reset values, `w_ready`=1, `x_ready`=0.
- Weight load: send beats (1,2,3),(4,5,6),(7,8,9) accepted at edges 0,1,2 → `load_weight` high in cycles 1–3 with `weights` matching each beat; `x_ready`=1 in cycle 3.
- Single vector: after the load, x=(1,2,3) with `x_last`=1 accepted at A → `iacts[0]`=1 at A+1, `iacts[1]`=2 at A+2, `iacts[2]`=3 at A+3, zeros elsewhere. `psum_valid[0..2]` are high at A+4, A+5, A+6, and in an integrated array run `psums[0]`=1·7+2·4+3·1=18. `busy`=0 at A+7.
- Stream with bubble: 4 vectors, with `x_valid` low for one cycle between the 2nd and 3rd → each `psum_valid` row shows the pattern 1,1,0,1,1, offset by one cycle per row.
- Load gaps and early vectors: `w_valid` toggling 1,0,1,0,1 and `x_valid` held high in IDLE/LOAD → exactly 3 `load_weight` pulses, no vector accepted before STREAM.
- Reset in DRAIN: assert `rst_n`=0 while `psum_valid[1]`=1 → all `psum_valid` and `iacts` are 0 immediately and the state is IDLE after release.
